histogram_accumulator: RTL and testbench

Builds a 256-bin, 16-bit intensity histogram from a streamed frame of pixels and hands each finished histogram to the histogram derivative stage through a valid/ready handshake. It sits directly upstream of the derivative stage. It uses two banks: a working bank that counts the current frame and an output bank that holds the last finished histogram. The next frame can therefore accumulate while downstream is still consuming the previous one.

---
 rtl/histogram_accumulator.sv | 105 ++++++++++
 tb/tb_histogram_accumulator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_accumulator.sv
// Two-bank 256-bin pixel histogram: a working bank counts the current frame while an output bank presents the last one.
// Optional build macro HIST_SATURATE_EN: bins saturate at 0xFFFF instead of wrapping.
module histogram_accumulator #(
    parameter int PIXEL_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [PIXEL_W-1:0]   i_pixel,
    input  logic                 i_pixel_valid,
    input  logic                 i_pixel_last,
    output logic                 o_pixel_ready,
    output logic [255:0][15:0]   o_histogram,
    output logic                 o_overflow,
    output logic                 o_valid,
    input  logic                 i_ready
);

    typedef enum logic {S_ACCUM, S_STALL} state_t;

    state_t              state;
    logic [255:0][15:0]  working;
    logic [255:0][15:0]  next_bank;
    logic                work_ovf;
    logic [7:0]          bin;
    logic [15:0]         cur;
    logic                at_max;
    logic                accept;
    logic                out_free;
    logic                unused_pixel;

    assign unused_pixel = ^i_pixel;

    // next_bank is the working bank with the current pixel's increment applied
    always_comb begin
        bin       = i_pixel[PIXEL_W-1 -: 8];
        cur       = working[bin];
        at_max    = (cur == 16'hFFFF);
        accept    = i_pixel_valid & o_pixel_ready;
        out_free  = !o_valid | i_ready;
        next_bank = working;
`ifdef HIST_SATURATE_EN
        if (!at_max) begin
            next_bank[bin] = cur + 16'd1;
        end
`else
        next_bank[bin] = cur + 16'd1;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_ACCUM;
            working       <= '0;
            work_ovf      <= 1'b0;
            o_histogram   <= '0;
            o_overflow    <= 1'b0;
            o_valid       <= 1'b0;
            o_pixel_ready <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (accept && i_pixel_last) begin
                        if (out_free) begin
                            o_histogram   <= next_bank;
                            o_overflow    <= work_ovf | at_max;
                            o_valid       <= 1'b1;
                            working       <= '0;
                            work_ovf      <= 1'b0;
                            o_pixel_ready <= 1'b1;
                        end else begin
                            working       <= next_bank;
                            work_ovf      <= work_ovf | at_max;
                            state         <= S_STALL;
                            o_pixel_ready <= 1'b0;
                        end
                    end else begin
                        if (accept) begin
                            working  <= next_bank;
                            work_ovf <= work_ovf | at_max;
                        end
                        if (o_valid && i_ready) begin
                            o_valid <= 1'b0;
                        end
                        o_pixel_ready <= 1'b1;
                    end
                end
                S_STALL: begin
                    // Only the downstream handshake releases a stalled frame
                    if (o_valid && i_ready) begin
                        o_histogram   <= working;
                        o_overflow    <= work_ovf;
                        working       <= '0;
                        work_ovf      <= 1'b0;
                        state         <= S_ACCUM;
                        o_pixel_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Directed, table-driven bench for histogram_accumulator (default 8-bit and a 10-bit instance).
module tb_histogram_accumulator;

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } pix_rec_t;

    typedef struct {
        int          bin;
        logic [15:0] count;
    } bin_chk_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           pixel = '0;
    logic                 pixel_valid = 1'b0;
    logic                 pixel_last = 1'b0;
    logic                 ready = 1'b0;
    logic                 pixel_ready;
    logic [255:0][15:0]   hist;
    logic                 overflow;
    logic                 valid;

    logic [9:0]           p10_pixel = '0;
    logic                 p10_valid = 1'b0;
    logic                 p10_last = 1'b0;
    logic                 p10_ready_in = 1'b0;
    logic                 p10_pixel_ready;
    logic [255:0][15:0]   p10_hist;
    logic                 p10_overflow;
    logic                 p10_out_valid;

    int checks = 0;
    int passes = 0;
    int exp_hist [256];
    pix_rec_t frame_a [4];
    bin_chk_t bins_a [4];
    logic [15:0] exp_bin7;

    always #5 clk = ~clk;

    histogram_accumulator #(.PIXEL_W(8)) dut (
        .i_clk(clk), .i_reset(reset), .i_pixel(pixel), .i_pixel_valid(pixel_valid),
        .i_pixel_last(pixel_last), .o_pixel_ready(pixel_ready), .o_histogram(hist),
        .o_overflow(overflow), .o_valid(valid), .i_ready(ready)
    );

    histogram_accumulator #(.PIXEL_W(10)) dut10 (
        .i_clk(clk), .i_reset(reset), .i_pixel(p10_pixel), .i_pixel_valid(p10_valid),
        .i_pixel_last(p10_last), .o_pixel_ready(p10_pixel_ready), .o_histogram(p10_hist),
        .o_overflow(p10_overflow), .o_valid(p10_out_valid), .i_ready(p10_ready_in)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic l);
        pixel_valid = v;
        pixel       = p;
        pixel_last  = l;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkHist(input string name, input logic [255:0][15:0] act);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int b = 0; b < 256; b++) begin
            if (act[b] !== exp_hist[b][15:0]) begin
                bad++;
                if (first < 0) first = b;
            end
        end
        checks++;
        if (bad == 0) passes++;
        else $display("[TB] FAIL %s: %0d bins differ, bin %0d got 0x%0h expected 0x%0h",
                      name, bad, first, act[first], exp_hist[first][15:0]);
    endtask

    task automatic clearModel();
        for (int b = 0; b < 256; b++) exp_hist[b] = 0;
    endtask

    initial begin
        frame_a[0] = '{pix: 8'h10, last: 1'b0};
        frame_a[1] = '{pix: 8'h10, last: 1'b0};
        frame_a[2] = '{pix: 8'hFF, last: 1'b0};
        frame_a[3] = '{pix: 8'h00, last: 1'b1};
        bins_a[0]  = '{bin: 16,  count: 16'd2};
        bins_a[1]  = '{bin: 255, count: 16'd1};
        bins_a[2]  = '{bin: 0,   count: 16'd1};
        bins_a[3]  = '{bin: 5,   count: 16'd0};
`ifdef HIST_SATURATE_EN
        exp_bin7 = 16'hFFFF;
`else
        exp_bin7 = 16'h0001;
`endif

        // Reset state
        tick();
        tick();
        clearModel();
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_pixel_ready", {31'd0, pixel_ready}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        checkHist("reset_hist", hist);
        reset = 1'b0;
        tick();
        checkOutput("release_pixel_ready", {31'd0, pixel_ready}, 32'd1);
        checkOutput("release_valid", {31'd0, valid}, 32'd0);

        // Frame A from the table, downstream ready
        ready = 1'b1;
        clearModel();
        for (int i = 0; i < 4; i++) begin
            exp_hist[frame_a[i].pix]++;
            applyStimulus(1'b1, frame_a[i].pix, frame_a[i].last);
        end
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        checkOutput("frameA_valid", {31'd0, valid}, 32'd1);
        checkOutput("frameA_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("frameA_bin%0d", bins_a[i].bin),
                        {16'd0, hist[bins_a[i].bin]}, {16'd0, bins_a[i].count});
        checkHist("frameA_hist", hist);
        tick();
        checkOutput("frameA_consumed_valid", {31'd0, valid}, 32'd0);

        // Back-to-back frames with downstream stalled
        ready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h05, (i == 2 || i == 5));
        checkOutput("stall_pixel_ready", {31'd0, pixel_ready}, 32'd0);
        checkOutput("stall_valid", {31'd0, valid}, 32'd1);
        checkOutput("stall_first_bin5", {16'd0, hist[5]}, 32'd3);
        applyStimulus(1'b1, 8'h09, 1'b1);
        applyStimulus(1'b1, 8'h09, 1'b1);
        checkOutput("stall_hold_valid", {31'd0, valid}, 32'd1);
        checkOutput("stall_hold_bin5", {16'd0, hist[5]}, 32'd3);
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checkOutput("handoff_valid", {31'd0, valid}, 32'd1);
        checkOutput("handoff_pixel_ready", {31'd0, pixel_ready}, 32'd1);
        clearModel();
        exp_hist[5] = 3;
        checkHist("handoff_second_hist", hist);
        tick();
        checkOutput("handoff_held_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick();
        checkOutput("handoff_consumed_valid", {31'd0, valid}, 32'd0);

        // Last without valid is ignored
        applyStimulus(1'b0, 8'h01, 1'b1);
        checkOutput("last_no_valid", {31'd0, valid}, 32'd0);

        // 65537 pixels into one bin
        for (int i = 0; i <= 65536; i++) applyStimulus(1'b1, 8'h07, (i == 65536));
        checkOutput("ovf_valid", {31'd0, valid}, 32'd1);
        checkOutput("ovf_bin7", {16'd0, hist[7]}, {16'd0, exp_bin7});
        checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);

        // Immediately following single-pixel frame, flag and bank cleared
        applyStimulus(1'b1, 8'h01, 1'b1);
        checkOutput("after_ovf_valid", {31'd0, valid}, 32'd1);
        checkOutput("after_ovf_flag", {31'd0, overflow}, 32'd0);
        clearModel();
        exp_hist[1] = 1;
        checkHist("after_ovf_hist", hist);

        // Reset in the middle of a frame while output is held
        ready = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h20, 1'b0);
        pixel_valid = 1'b0;
        reset = 1'b1;
        ready = 1'b1;
        tick();
        checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
        checkOutput("midreset_pixel_ready", {31'd0, pixel_ready}, 32'd0);
        checkOutput("midreset_bin1", {16'd0, hist[1]}, 32'd0);
        reset = 1'b0;
        ready = 1'b0;
        tick();
        checkOutput("midreset_release_ready", {31'd0, pixel_ready}, 32'd1);
        applyStimulus(1'b1, 8'h03, 1'b1);
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        checkOutput("midreset_frame_valid", {31'd0, valid}, 32'd1);
        checkOutput("midreset_bin32", {16'd0, hist[32]}, 32'd0);
        clearModel();
        exp_hist[3] = 1;
        checkHist("midreset_hist", hist);

        // 10-bit pixels use the top 8 bits as the bin
        p10_valid = 1'b1;
        p10_pixel = 10'h3FF;
        p10_last  = 1'b0;
        tick();
        p10_pixel = 10'h004;
        p10_last  = 1'b1;
        tick();
        p10_valid = 1'b0;
        p10_last  = 1'b0;
        checkOutput("w10_valid", {31'd0, p10_out_valid}, 32'd1);
        checkOutput("w10_bin255", {16'd0, p10_hist[255]}, 32'd1);
        checkOutput("w10_bin1", {16'd0, p10_hist[1]}, 32'd1);
        checkOutput("w10_bin4", {16'd0, p10_hist[4]}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
